moldudp64_feed_arbiter: RTL and testbench

- Parametrised successor to the single-feed receive path: merges NUM_CH redundant MoldUDP64/ITCH feeds (A/B lines, each behind its own eth_udp_parser) into one sequenced ITCH byte stream for itch_parser.
- Tracks the expected MoldUDP64 sequence number, forwards each packet once, and drops duplicates.
- Reports gaps (lost messages) and per-channel line staleness.
- Sits in the 250MHz domain, between the per-channel eth_udp_parser instances and itch_parser.

---
 rtl/feed_arb_pkg.sv | 23 ++
 rtl/feed_ch_monitor.sv | 67 ++++++
 rtl/moldudp64_feed_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_moldudp64_feed_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/feed_arb_pkg.sv
// Shared types and widths for the redundant MoldUDP64 feed arbiter.
package feed_arb_pkg;

    localparam int unsigned SEQ_W           = 64;
    localparam int unsigned MSGCNT_W        = 16;
    localparam int unsigned BEAT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD     = 2'd1,
        DISCARD = 2'd2
    } chStateType;

    // One cycle of the merged ITCH stream.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       abort;
        logic       valid;
        logic [7:0] data;
    } itchBeatType;

endpackage

// File: rtl/feed_ch_monitor.sv
// Per-channel packet state, latched end sequence number and line staleness.
module feed_ch_monitor
    import feed_arb_pkg::*;
#(
    parameter int unsigned STALE_CYCLES = 250000000
) (
    input  logic                clk,
    input  logic                rstB,
    input  logic                sop,
    input  logic                eop,
    input  logic                dataValid,
    input  logic                grant,
    input  logic [SEQ_W-1:0]    seqNum,
    input  logic [MSGCNT_W-1:0] msgCnt,
    output logic                fwd,
    output logic [SEQ_W-1:0]    endSeq,
    output logic                stale
);

    localparam int unsigned STALE_W = $clog2(STALE_CYCLES + 1);

    chStateType         stateQ;
    chStateType         stateNext;
    logic [STALE_W-1:0] staleCnt;
    logic [STALE_W-1:0] staleCntNext;

    // A sop always restarts evaluation; heartbeats and one-beat packets never linger.
    always_comb begin
        stateNext    = stateQ;
        staleCntNext = staleCnt;
        if (sop) begin
            if (msgCnt == '0 || eop) begin
                stateNext = IDLE;
            end else if (grant) begin
                stateNext = FWD;
            end else begin
                stateNext = DISCARD;
            end
        end else if (eop) begin
            stateNext = IDLE;
        end
        if (sop || dataValid) begin
            staleCntNext = '0;
        end else if (staleCnt != STALE_W'(STALE_CYCLES)) begin
            staleCntNext = staleCnt + STALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            stateQ   <= IDLE;
            endSeq   <= '0;
            staleCnt <= '0;
            stale    <= 1'b0;
        end else begin
            stateQ   <= stateNext;
            if (sop) begin
                endSeq <= seqNum + SEQ_W'(msgCnt);
            end
            staleCnt <= staleCntNext;
            stale    <= (staleCntNext == STALE_W'(STALE_CYCLES));
        end
    end

    assign fwd = (stateQ == FWD);

endmodule

// File: rtl/moldudp64_feed_arbiter.sv
// Merges NUM_CH redundant MoldUDP64 feeds into one sequenced ITCH byte stream,
// dropping duplicates and reporting gaps.
module moldudp64_feed_arbiter
    import feed_arb_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned STALE_CYCLES = 250000000,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clkIn,
    input  logic                       rstBIn,
    input  logic [NUM_CH*8-1:0]        dataIn,
    input  logic [NUM_CH-1:0]          dataValidIn,
    input  logic [NUM_CH-1:0]          sopIn,
    input  logic [NUM_CH-1:0]          eopIn,
    input  logic [NUM_CH*SEQ_W-1:0]    seqNumIn,
    input  logic [NUM_CH*MSGCNT_W-1:0] msgCntIn,
    output logic [7:0]                 itchDataOut,
    output logic                       itchDataValidOut,
    output logic                       itchSopOut,
    output logic                       itchEopOut,
    output logic                       itchAbortOut,
    output logic                       packetLostOut,
    output logic [SEQ_W-1:0]           lostMsgsOut,
    output logic [CH_W-1:0]            activeChOut,
    output logic [NUM_CH-1:0]          chStaleOut,
    output logic [CNT_W-1:0]           dupDropCntOut,
    output logic [CNT_W-1:0]           gapCntOut
);

    localparam int unsigned PTR_W  = $clog2(BEAT_FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(BEAT_FIFO_DEPTH + 1);

    logic [NUM_CH-1:0] chFwd;
    logic [NUM_CH-1:0] grant;
    logic [SEQ_W-1:0]  chEndSeq [NUM_CH];

    logic [SEQ_W-1:0]  expSeq, expNext;
    logic              synced, syncNext;
    logic              busy, gapSeen, newSingle;
    logic [SEQ_W-1:0]  lostSum, newEnd, seqC, diffC;
    logic [MSGCNT_W-1:0] cntC;
    logic [2:0]        dupInc;
    logic [CH_W-1:0]   activeNext;
    logic [CNT_W:0]    dupSum;
    logic [CNT_W-1:0]  dupNext, gapNext;

    itchBeatType       oldBeat, newBeat, slot0, slot1, outBeat;
    logic              slot0V, slot1V;
    itchBeatType       beatQ [BEAT_FIFO_DEPTH];
    itchBeatType       qNext [BEAT_FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr, rdNext, wrNext;
    logic [FCNT_W-1:0] fCnt, fCntNext;

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        feed_ch_monitor #(.STALE_CYCLES(STALE_CYCLES)) uMon (
            .clk       (clkIn),
            .rstB      (rstBIn),
            .sop       (sopIn[c]),
            .eop       (eopIn[c]),
            .dataValid (dataValidIn[c]),
            .grant     (grant[c]),
            .seqNum    (seqNumIn[c*SEQ_W +: SEQ_W]),
            .msgCnt    (msgCntIn[c*MSGCNT_W +: MSGCNT_W]),
            .fwd       (chFwd[c]),
            .endSeq    (chEndSeq[c]),
            .stale     (chStaleOut[c])
        );
    end

    // Arbitration: finish or abort the forwarding channel, then evaluate sops by priority.
    always_comb begin
        grant      = '0;
        expNext    = expSeq;
        syncNext   = synced;
        busy       = 1'b0;
        gapSeen    = 1'b0;
        newSingle  = 1'b0;
        lostSum    = '0;
        newEnd     = '0;
        seqC       = '0;
        cntC       = '0;
        diffC      = '0;
        dupInc     = '0;
        activeNext = activeChOut;
        oldBeat    = '0;
        newBeat    = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (chFwd[c]) begin
                if (sopIn[c]) begin
                    oldBeat.eop   = 1'b1;
                    oldBeat.abort = 1'b1;
                end else begin
                    oldBeat.valid = dataValidIn[c];
                    oldBeat.data  = dataValidIn[c] ? dataIn[c*8 +: 8] : 8'h00;
                    oldBeat.eop   = eopIn[c];
                    if (eopIn[c]) begin
                        expNext = chEndSeq[c];
                    end else begin
                        busy = 1'b1;
                    end
                end
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (sopIn[c]) begin
                seqC = seqNumIn[c*SEQ_W +: SEQ_W];
                cntC = msgCntIn[c*MSGCNT_W +: MSGCNT_W];
                if (!syncNext) begin
                    expNext  = seqC;
                    syncNext = 1'b1;
                end
                diffC = seqC + SEQ_W'(cntC) - expNext;
                if (cntC == '0) begin
                    diffC = seqC - expNext;
                    if (!diffC[SEQ_W-1] && diffC != '0) begin
                        gapSeen = 1'b1;
                        lostSum = lostSum + diffC;
                        expNext = seqC;
                    end
                end else if (diffC[SEQ_W-1] || diffC == '0) begin
                    dupInc = dupInc + 3'd1;
                end else if (!busy) begin
                    grant[c]      = 1'b1;
                    busy          = 1'b1;
                    activeNext    = CH_W'(c);
                    newBeat.sop   = 1'b1;
                    newBeat.eop   = eopIn[c];
                    newBeat.valid = dataValidIn[c];
                    newBeat.data  = dataValidIn[c] ? dataIn[c*8 +: 8] : 8'h00;
                    newSingle     = eopIn[c];
                    newEnd        = seqC + SEQ_W'(cntC);
                    diffC         = seqC - expNext;
                    if (!diffC[SEQ_W-1] && diffC != '0) begin
                        gapSeen = 1'b1;
                        lostSum = lostSum + diffC;
                        expNext = seqC;
                    end
                end
            end
        end
        if (newSingle) begin
            expNext = newEnd;
        end

        dupSum  = {1'b0, dupDropCntOut} + (CNT_W+1)'(dupInc);
        dupNext = dupSum[CNT_W] ? '1 : dupSum[CNT_W-1:0];
        gapNext = (gapSeen && gapCntOut != '1) ? gapCntOut + CNT_W'(1) : gapCntOut;
    end

    // Small beat queue absorbs the rare cycle where an ending/aborted packet and a new sop collide.
    always_comb begin
        slot0    = (oldBeat != '0) ? oldBeat : newBeat;
        slot0V   = (oldBeat != '0) || (grant != '0);
        slot1    = newBeat;
        slot1V   = (oldBeat != '0) && (grant != '0);
        qNext    = beatQ;
        rdNext   = rdPtr;
        wrNext   = wrPtr;
        fCntNext = fCnt;
        outBeat  = '0;
        if (fCnt != '0) begin
            outBeat  = beatQ[rdPtr];
            rdNext   = rdPtr + PTR_W'(1);
            fCntNext = fCnt - FCNT_W'(1);
        end else if (slot0V) begin
            outBeat = slot0;
            slot0   = slot1;
            slot0V  = slot1V;
            slot1V  = 1'b0;
        end
        if (slot0V && fCntNext < FCNT_W'(BEAT_FIFO_DEPTH)) begin
            qNext[wrNext] = slot0;
            wrNext        = wrNext + PTR_W'(1);
            fCntNext      = fCntNext + FCNT_W'(1);
        end
        if (slot1V && fCntNext < FCNT_W'(BEAT_FIFO_DEPTH)) begin
            qNext[wrNext] = slot1;
            wrNext        = wrNext + PTR_W'(1);
            fCntNext      = fCntNext + FCNT_W'(1);
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            expSeq           <= '0;
            synced           <= 1'b0;
            for (int i = 0; i < BEAT_FIFO_DEPTH; i++) begin
                beatQ[i] <= '0;
            end
            rdPtr            <= '0;
            wrPtr            <= '0;
            fCnt             <= '0;
            itchDataOut      <= '0;
            itchDataValidOut <= 1'b0;
            itchSopOut       <= 1'b0;
            itchEopOut       <= 1'b0;
            itchAbortOut     <= 1'b0;
            packetLostOut    <= 1'b0;
            lostMsgsOut      <= '0;
            activeChOut      <= '0;
            dupDropCntOut    <= '0;
            gapCntOut        <= '0;
        end else begin
            expSeq           <= expNext;
            synced           <= syncNext;
            beatQ            <= qNext;
            rdPtr            <= rdNext;
            wrPtr            <= wrNext;
            fCnt             <= fCntNext;
            itchDataOut      <= outBeat.data;
            itchDataValidOut <= outBeat.valid;
            itchSopOut       <= outBeat.sop;
            itchEopOut       <= outBeat.eop;
            itchAbortOut     <= outBeat.abort;
            packetLostOut    <= gapSeen;
            lostMsgsOut      <= lostSum;
            activeChOut      <= activeNext;
            dupDropCntOut    <= dupNext;
            gapCntOut        <= gapNext;
        end
    end

endmodule

// File: tb/tb_moldudp64_feed_arbiter.sv
// Directed scoreboard bench for the two-channel MoldUDP64 feed arbiter.
module tb_moldudp64_feed_arbiter;

    localparam int NSLOT = 2;

    logic         clk = 1'b0;
    logic         rstB;
    logic [15:0]  dataIn;
    logic [1:0]   dataValidIn, sopIn, eopIn;
    logic [127:0] seqNumIn;
    logic [31:0]  msgCntIn;
    logic [7:0]   itchDataOut;
    logic         itchDataValidOut, itchSopOut, itchEopOut, itchAbortOut, packetLostOut;
    logic [63:0]  lostMsgsOut;
    logic [0:0]   activeChOut;
    logic [1:0]   chStaleOut;
    logic [31:0]  dupDropCntOut, gapCntOut;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    int          pCh [NSLOT];
    int          pStart [NSLOT];
    int          pLen [NSLOT];
    logic [63:0] pSeq [NSLOT];
    logic [15:0] pCnt [NSLOT];
    logic [7:0]  pBase [NSLOT];
    bit          pEop [NSLOT];

    logic [11:0] expQ [$];
    logic [11:0] obsBeat;

    moldudp64_feed_arbiter #(.NUM_CH(2), .STALE_CYCLES(100), .CNT_W(32)) dut (
        .clkIn(clk), .rstBIn(rstB), .dataIn(dataIn), .dataValidIn(dataValidIn),
        .sopIn(sopIn), .eopIn(eopIn), .seqNumIn(seqNumIn), .msgCntIn(msgCntIn),
        .itchDataOut(itchDataOut), .itchDataValidOut(itchDataValidOut),
        .itchSopOut(itchSopOut), .itchEopOut(itchEopOut), .itchAbortOut(itchAbortOut),
        .packetLostOut(packetLostOut), .lostMsgsOut(lostMsgsOut), .activeChOut(activeChOut),
        .chStaleOut(chStaleOut), .dupDropCntOut(dupDropCntOut), .gapCntOut(gapCntOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        assert (obs === expv) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Every merged beat must match the next expected beat in order.
    always @(negedge clk) begin
        if (itchDataValidOut || itchSopOut || itchEopOut || itchAbortOut) begin
            obsBeat = {itchSopOut, itchEopOut, itchAbortOut, itchDataValidOut, itchDataOut};
            if (expQ.size() == 0) chk("extra_beat", 64'(obsBeat), 64'h0);
            else chk("beat", 64'(obsBeat), 64'(expQ.pop_front()));
        end
    end

    task automatic setPkt(input int s, input int ch, input int off, input int len,
                          input logic [63:0] seq, input logic [15:0] cnt, input logic [7:0] base,
                          input bit eop, input int nFwd);
        logic [11:0] b;
        pCh[s] = ch; pStart[s] = cyc + off; pLen[s] = len;
        pSeq[s] = seq; pCnt[s] = cnt; pBase[s] = base; pEop[s] = eop;
        for (int i = 0; i < nFwd; i++) begin
            b = {(i == 0), ((i == len - 1) && eop), 1'b0, 1'b1, base + 8'(i)};
            expQ.push_back(b);
        end
    endtask

    task automatic run(input int n);
        int off;
        int c;
        for (int k = 0; k < n; k++) begin
            dataIn = '0; dataValidIn = '0; sopIn = '0; eopIn = '0; seqNumIn = '0; msgCntIn = '0;
            for (int s = 0; s < NSLOT; s++) begin
                off = cyc - pStart[s];
                if (off >= 0 && off < pLen[s]) begin
                    c = pCh[s];
                    sopIn[c]        = (off == 0);
                    eopIn[c]        = (off == pLen[s] - 1) && pEop[s];
                    dataValidIn[c]  = (pCnt[s] != 16'd0);
                    dataIn[c*8 +: 8] = (pCnt[s] != 16'd0) ? pBase[s] + 8'(off) : 8'h00;
                    if (off == 0) begin
                        seqNumIn[c*64 +: 64] = pSeq[s];
                        msgCntIn[c*16 +: 16] = pCnt[s];
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_valid"}, itchDataValidOut, 0);
        chk({tag, "_data"}, itchDataOut, 0);
        chk({tag, "_sop"}, itchSopOut, 0);
        chk({tag, "_eop"}, itchEopOut, 0);
        chk({tag, "_abort"}, itchAbortOut, 0);
        chk({tag, "_lost"}, packetLostOut, 0);
        chk({tag, "_lostmsgs"}, lostMsgsOut, 0);
        chk({tag, "_active"}, activeChOut, 0);
        chk({tag, "_stale"}, chStaleOut, 0);
        chk({tag, "_dup"}, dupDropCntOut, 0);
        chk({tag, "_gap"}, gapCntOut, 0);
    endtask

    initial begin
        rstB = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
            pCh[s] = 0; pStart[s] = 0; pLen[s] = 0; pSeq[s] = '0; pCnt[s] = '0; pBase[s] = '0; pEop[s] = 0;
        end
        run(3);
        chkAllZero("reset");
        rstB = 1'b1;

        // First packet syncs; identical copy on ch1 after it completes is a duplicate.
        setPkt(0, 0, 0, 20, 64'd100, 16'd3, 8'h10, 1, 20);
        setPkt(1, 1, 25, 20, 64'd100, 16'd3, 8'h10, 1, 0);
        run(1);
        chk("t1_sop", itchSopOut, 1);
        chk("t1_data", itchDataOut, 8'h10);
        chk("t1_nogap", packetLostOut, 0);
        run(48);
        chk("t1_dup", dupDropCntOut, 1);
        chk("t1_q_empty", 64'(expQ.size()), 0);

        // Simultaneous sop, both seq=103: ch0 wins, ch1 dropped without counting.
        setPkt(0, 0, 0, 8, 64'd103, 16'd2, 8'h40, 1, 8);
        setPkt(1, 1, 0, 8, 64'd103, 16'd2, 8'h80, 1, 0);
        run(1);
        chk("t2_active", activeChOut, 0);
        chk("t2_data", itchDataOut, 8'h40);
        run(10);
        chk("t2_dup", dupDropCntOut, 1);

        // Gap: expSeq 105, ch1 seq 112.
        setPkt(1, 1, 0, 6, 64'd112, 16'd2, 8'hA0, 1, 6);
        run(1);
        chk("t3_lost", packetLostOut, 1);
        chk("t3_lostmsgs", lostMsgsOut, 7);
        chk("t3_gapcnt", gapCntOut, 1);
        chk("t3_active", activeChOut, 1);
        run(1);
        chk("t3_pulse", packetLostOut, 0);
        run(6);

        // Heartbeat gap: expSeq 114, heartbeat seq 122.
        setPkt(0, 0, 0, 1, 64'd122, 16'd0, 8'h00, 1, 0);
        run(1);
        chk("t4_lost", packetLostOut, 1);
        chk("t4_lostmsgs", lostMsgsOut, 8);
        chk("t4_nosop", itchSopOut, 0);
        chk("t4_novalid", itchDataValidOut, 0);
        run(2);
        setPkt(1, 1, 0, 1, 64'd100, 16'd0, 8'h00, 1, 0);
        run(1);
        chk("t4_oldhb_nolost", packetLostOut, 0);
        chk("t4_oldhb_nodup", dupDropCntOut, 1);
        run(1);

        // Truncated packet: second sop on ch0 without eop.
        setPkt(0, 0, 0, 6, 64'd122, 16'd2, 8'hC0, 0, 6);
        expQ.push_back({1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        setPkt(1, 0, 6, 5, 64'd122, 16'd2, 8'hD0, 1, 5);
        run(7);
        chk("t5_abort", itchAbortOut, 1);
        chk("t5_abort_eop", itchEopOut, 1);
        chk("t5_abort_novalid", itchDataValidOut, 0);
        run(8);
        chk("t5_q_empty", 64'(expQ.size()), 0);

        // expSeq must now be 124 (truncated copy did not advance it).
        setPkt(1, 1, 0, 3, 64'd124, 16'd1, 8'hE0, 1, 3);
        run(1);
        chk("t6_sop", itchSopOut, 1);
        chk("t6_nogap", packetLostOut, 0);
        run(4);
        setPkt(0, 0, 0, 1, 64'd128, 16'd0, 8'h00, 1, 0);
        run(1);
        chk("t6_hb_lost", packetLostOut, 1);
        chk("t6_hb_lostmsgs", lostMsgsOut, 3);
        run(1);

        // Staleness on ch1 with a 100-cycle threshold.
        setPkt(1, 1, 0, 1, 64'd128, 16'd0, 8'h00, 1, 0);
        run(1);
        run(99);
        chk("t7_stale_before", chStaleOut[1], 0);
        run(1);
        chk("t7_stale_at", chStaleOut[1], 1);
        setPkt(1, 1, 0, 1, 64'd128, 16'd0, 8'h00, 1, 0);
        run(1);
        chk("t7_stale_clear", chStaleOut[1], 0);
        run(1);

        // Reset in the middle of a forwarded packet.
        setPkt(1, 1, 0, 10, 64'd500, 16'd2, 8'h30, 1, 4);
        run(1);
        chk("t8_lostmsgs", lostMsgsOut, 372);
        run(3);
        rstB = 1'b0;
        pLen[0] = 0; pLen[1] = 0;
        run(1);
        chkAllZero("midrst");
        rstB = 1'b1;
        setPkt(1, 1, 0, 2, 64'd7, 16'd1, 8'h55, 1, 2);
        run(1);
        chk("t8_resync_sop", itchSopOut, 1);
        chk("t8_resync_nogap", packetLostOut, 0);
        chk("t8_resync_active", activeChOut, 1);
        run(4);
        chk("final_q_empty", 64'(expQ.size()), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
